// File: rtl/ff_lockstep_checker.sv
// Lockstep monitor: compares a DUT flop against a golden flop every edge,
// counts compared cycles and errors, and captures the first failure.
module ff_lockstep_checker #(
   parameter int CNT_W       = 16,
   parameter int WARMUP      = 1,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             dut_q,
   input  logic             dut_qbar,
   input  logic             ref_q,
   input  logic             ref_qbar,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] first_err_cyc,
   output logic [2:0]       first_err_code
);

   typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_HALT} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'((WARMUP > 0) ? (WARMUP - 1) : 0);
   localparam state_t           START_ST  = (WARMUP == 0) ? S_RUN : S_WARM;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] warm_q, warm_d;
   logic             fail_q, fail_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] cyc_q, cyc_d;
   logic [CNT_W-1:0] fec_q, fec_d;
   logic [2:0]       fcode_q, fcode_d;

   logic [2:0] code;
   logic       cmp_err;

   assign code    = {dut_q == dut_qbar, dut_qbar != ref_qbar, dut_q != ref_q};
   assign cmp_err = |code;

   always_comb begin
      state_d = state_q;
      warm_d  = warm_q;
      fail_d  = fail_q;
      err_d   = err_q;
      cyc_d   = cyc_q;
      fec_d   = fec_q;
      fcode_d = fcode_q;
      // start restarts the run from any state and outranks stop
      if (start) begin
         state_d = START_ST;
         warm_d  = '0;
         fail_d  = 1'b0;
         err_d   = '0;
         cyc_d   = '0;
         fec_d   = '0;
         fcode_d = '0;
      end else begin
         case (state_q)
            S_WARM: begin
               if (stop)                  state_d = S_HALT;
               else if (warm_q == WARM_LAST) state_d = S_RUN;
               else                       warm_d  = warm_q + 1'b1;
            end
            S_RUN: begin
               cyc_d = (cyc_q == CNT_MAX) ? cyc_q : cyc_q + 1'b1;
               if (cmp_err) begin
                  err_d  = (err_q == CNT_MAX) ? err_q : err_q + 1'b1;
                  fail_d = 1'b1;
                  if (!fail_q) begin
                     fec_d   = cyc_q;
                     fcode_d = code;
                  end
               end
               if (stop || (STOP_ON_ERR && cmp_err)) state_d = S_HALT;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         warm_q  <= '0;
         fail_q  <= 1'b0;
         err_q   <= '0;
         cyc_q   <= '0;
         fec_q   <= '0;
         fcode_q <= '0;
      end else begin
         state_q <= state_d;
         warm_q  <= warm_d;
         fail_q  <= fail_d;
         err_q   <= err_d;
         cyc_q   <= cyc_d;
         fec_q   <= fec_d;
         fcode_q <= fcode_d;
      end
   end

   assign busy           = (state_q == S_WARM) || (state_q == S_RUN);
   assign done           = (state_q == S_HALT);
   assign fail           = fail_q;
   assign err_cnt        = err_q;
   assign cyc_cnt        = cyc_q;
   assign first_err_cyc  = fec_q;
   assign first_err_code = fcode_q;

endmodule

// File: tb/tb_ff_lockstep_checker.sv
// Bench for ff_lockstep_checker: three configurations share one stimulus stream;
// a behavioural model feeds a scoreboard compared after every edge.
module tb_ff_lockstep_checker;

   logic clk = 1'b0;
   logic rst = 1'b0, start = 1'b0, stop = 1'b0;
   logic dut_q = 1'b0, dut_qbar = 1'b1, ref_q = 1'b0, ref_qbar = 1'b1;

   // inst 0: CNT_W=16 WARMUP=1 STOP_ON_ERR=0; inst 1: same with STOP_ON_ERR=1;
   // inst 2: CNT_W=4 WARMUP=0 STOP_ON_ERR=0
   logic        busy_a, done_a, fail_a, busy_b, done_b, fail_b, busy_c, done_c, fail_c;
   logic [15:0] err_a, cyc_a, fec_a, err_b, cyc_b, fec_b;
   logic [3:0]  err_c, cyc_c, fec_c;
   logic [2:0]  fc_a, fc_b, fc_c;

   ff_lockstep_checker #(.CNT_W(16), .WARMUP(1), .STOP_ON_ERR(1'b0)) u_a (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .dut_q(dut_q), .dut_qbar(dut_qbar),
      .ref_q(ref_q), .ref_qbar(ref_qbar), .busy(busy_a), .done(done_a), .fail(fail_a),
      .err_cnt(err_a), .cyc_cnt(cyc_a), .first_err_cyc(fec_a), .first_err_code(fc_a));
   ff_lockstep_checker #(.CNT_W(16), .WARMUP(1), .STOP_ON_ERR(1'b1)) u_b (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .dut_q(dut_q), .dut_qbar(dut_qbar),
      .ref_q(ref_q), .ref_qbar(ref_qbar), .busy(busy_b), .done(done_b), .fail(fail_b),
      .err_cnt(err_b), .cyc_cnt(cyc_b), .first_err_cyc(fec_b), .first_err_code(fc_b));
   ff_lockstep_checker #(.CNT_W(4), .WARMUP(0), .STOP_ON_ERR(1'b0)) u_c (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .dut_q(dut_q), .dut_qbar(dut_qbar),
      .ref_q(ref_q), .ref_qbar(ref_qbar), .busy(busy_c), .done(done_c), .fail(fail_c),
      .err_cnt(err_c), .cyc_cnt(cyc_c), .first_err_cyc(fec_c), .first_err_code(fc_c));

   always #5 clk = ~clk;

   localparam int ST_IDLE = 0, ST_WARM = 1, ST_RUN = 2, ST_HALT = 3;
   localparam int P_CW [3] = '{16, 16, 4};
   localparam int P_WU [3] = '{1, 1, 0};
   localparam int P_SOE[3] = '{0, 1, 0};

   typedef struct {
      int inst;
      int busy, done, fail, err, cyc, fec, fc;
   } exp_t;
   exp_t sb[$];

   int m_st[3], m_wc[3], m_fail[3], m_err[3], m_cyc[3], m_fec[3], m_fc[3];
   int n_chk = 0, n_err = 0;
   bit ffq = 1'b0;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d @%0t", tag, act, exp, $time);
      end
   endtask

   task automatic model(input int i, input bit r, s, p, dq, dqb, rq, rqb);
      int mx, c;
      mx = (1 << P_CW[i]) - 1;
      c  = ((dq != rq) ? 1 : 0) | ((dqb != rqb) ? 2 : 0) | ((dq == dqb) ? 4 : 0);
      if (r) begin
         m_st[i] = ST_IDLE; m_wc[i] = 0; m_fail[i] = 0; m_err[i] = 0;
         m_cyc[i] = 0; m_fec[i] = 0; m_fc[i] = 0;
      end else if (s) begin
         m_st[i] = (P_WU[i] == 0) ? ST_RUN : ST_WARM; m_wc[i] = 0; m_fail[i] = 0;
         m_err[i] = 0; m_cyc[i] = 0; m_fec[i] = 0; m_fc[i] = 0;
      end else if (m_st[i] == ST_WARM) begin
         if (p) m_st[i] = ST_HALT;
         else if (m_wc[i] == P_WU[i] - 1) m_st[i] = ST_RUN;
         else m_wc[i]++;
      end else if (m_st[i] == ST_RUN) begin
         if (c != 0) begin
            if (m_fail[i] == 0) begin m_fec[i] = m_cyc[i]; m_fc[i] = c; end
            m_fail[i] = 1;
            if (m_err[i] < mx) m_err[i]++;
         end
         if (m_cyc[i] < mx) m_cyc[i]++;
         if (p || (P_SOE[i] == 1 && c != 0)) m_st[i] = ST_HALT;
      end
   endtask

   task automatic get_act(input int i, output int b, d, f, e, c, fe, fc);
      case (i)
         0: begin b = busy_a; d = done_a; f = fail_a; e = err_a; c = cyc_a; fe = fec_a; fc = fc_a; end
         1: begin b = busy_b; d = done_b; f = fail_b; e = err_b; c = cyc_b; fe = fec_b; fc = fc_b; end
         default: begin b = busy_c; d = done_c; f = fail_c; e = err_c; c = cyc_c; fe = fec_c; fc = fc_c; end
      endcase
   endtask

   // fq: invert dut_q; qb0: dut_qbar stuck 0 with golden q held 0 so it always mismatches
   task automatic step(input bit r, s, p, fq, qb0);
      exp_t e;
      int b, d, f, er, c, fe, fc;
      if (qb0) ffq = 1'b0;
      rst = r; start = s; stop = p;
      ref_q = ffq; ref_qbar = ~ffq;
      dut_q = fq ? ~ffq : ffq;
      dut_qbar = qb0 ? 1'b0 : ~ffq;
      for (int i = 0; i < 3; i++) begin
         model(i, r, s, p, dut_q, dut_qbar, ref_q, ref_qbar);
         e.inst = i; e.busy = (m_st[i] == ST_WARM || m_st[i] == ST_RUN) ? 1 : 0;
         e.done = (m_st[i] == ST_HALT) ? 1 : 0; e.fail = m_fail[i]; e.err = m_err[i];
         e.cyc = m_cyc[i]; e.fec = m_fec[i]; e.fc = m_fc[i];
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      ffq = 1'($urandom_range(0, 1));
      while (sb.size() > 0) begin
         e = sb.pop_front();
         get_act(e.inst, b, d, f, er, c, fe, fc);
         chk($sformatf("u%0d.busy", e.inst), b, e.busy);
         chk($sformatf("u%0d.done", e.inst), d, e.done);
         chk($sformatf("u%0d.fail", e.inst), f, e.fail);
         chk($sformatf("u%0d.err_cnt", e.inst), er, e.err);
         chk($sformatf("u%0d.cyc_cnt", e.inst), c, e.cyc);
         chk($sformatf("u%0d.first_err_cyc", e.inst), fe, e.fec);
         chk($sformatf("u%0d.first_err_code", e.inst), fc, e.fc);
      end
   endtask

   initial begin
      @(negedge clk);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("reset.busy", busy_a, 0); chk("reset.done", done_a, 0);
      chk("reset.fail", fail_a, 0); chk("reset.cyc", cyc_a, 0);

      // start and stop together in IDLE: start wins
      step(0, 1, 1, 0, 0);
      chk("ss_idle.busy", busy_a, 1);

      // clean run: 2000 cycles after start, first one is warmup, stop on the last
      step(0, 1, 0, 0, 0);
      for (int k = 1; k <= 2000; k++) step(0, 0, (k == 2000), 0, 0);
      chk("t1.done", done_a, 1); chk("t1.fail", fail_a, 0);
      chk("t1.err", err_a, 0);   chk("t1.cyc", cyc_a, 1999);
      chk("t1.c_sat", cyc_c, 15);

      // single inverted dut_q on compare 10 (step 12 after start)
      step(0, 1, 0, 0, 0);
      for (int k = 1; k <= 20; k++) step(0, 0, 0, (k == 12), 0);
      chk("t2.fail", fail_a, 1); chk("t2.err", err_a, 1);
      chk("t2.fec", fec_a, 10);  chk("t2.code", fc_a, 5);
      chk("t2.busy", busy_a, 1); chk("t2.b_done", done_b, 1);
      step(0, 0, 1, 0, 0);

      // dut_qbar stuck 0 from compare 5 on
      step(0, 1, 0, 0, 0);
      for (int k = 1; k <= 12; k++) step(0, 0, 0, 0, (k >= 7));
      chk("t3.done", done_b, 1); chk("t3.err", err_b, 1);
      chk("t3.fec", fec_b, 5);   chk("t3.cyc", cyc_b, 6);
      chk("t3.code", fc_b, 6);
      step(0, 0, 1, 0, 0);

      // permanent mismatch saturates the 4-bit counters
      step(0, 1, 0, 0, 0);
      for (int k = 1; k <= 40; k++) step(0, 0, 0, 1, 0);
      chk("t4.err", err_c, 15); chk("t4.cyc", cyc_c, 15); chk("t4.fail", fail_c, 1);
      step(0, 0, 1, 0, 0);

      // reset in the middle of a failing run
      step(0, 1, 0, 0, 0);
      for (int k = 1; k <= 8; k++) step(0, 0, 0, (k == 5), 0);
      chk("t5.pre_fail", fail_a, 1);
      step(1, 0, 0, 0, 0);
      chk("t5.busy", busy_a, 0); chk("t5.fail", fail_a, 0);
      chk("t5.err", err_a, 0);   chk("t5.fec", fec_a, 0);
      step(0, 1, 0, 0, 0);
      for (int k = 1; k <= 11; k++) step(0, 0, 0, 0, 0);
      chk("t5.cyc", cyc_a, 10); chk("t5.clean", fail_a, 0);
      step(0, 0, 1, 0, 0);

      // restart during RUN clears everything and re-enters warmup
      step(0, 1, 0, 0, 0);
      for (int k = 1; k <= 6; k++) step(0, 0, 0, (k >= 2 && k <= 4), 0);
      chk("t6.pre_err", err_a, 3);
      step(0, 1, 1, 0, 0);
      chk("t6.err", err_a, 0); chk("t6.fail", fail_a, 0);
      chk("t6.cyc", cyc_a, 0); chk("t6.busy", busy_a, 1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("t6.cyc1", cyc_a, 1);
      step(0, 0, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
